// File: rtl/router_fifo.sv
// One output FIFO of the 1x3 router: 16 x 9-bit storage (lfd marker + byte)
// with read-side packet tracking that releases the output bus between packets.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    logic [DATA_W:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [5:0]        pkt_count_r;
    logic [DATA_W-1:0] data_r;
    logic              oe_r;

    logic              empty_s;
    logic              full_s;
    logic              do_wr_s;
    logic              do_rd_s;
    logic [DATA_W:0]   rd_word_s;
    logic [5:0]        pkt_count_next_s;
    logic [DATA_W-1:0] data_next_s;
    logic              oe_next_s;

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
    assign do_wr_s   = write_enb & ~full_s;
    assign do_rd_s   = read_enb & ~empty_s;
    assign rd_word_s = mem_r[rd_ptr_r[PTR_W-2:0]];

    assign empty     = empty_s;
    assign full      = full_s;
    assign data_out  = oe_r ? data_r : {DATA_W{1'bz}};

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s && !soft_reset) begin
            mem_r[wr_ptr_r[PTR_W-2:0]] <= {lfd_state, data_in};
        end
    end

    // Write and read pointers.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (soft_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Packet length tracking and output bus ownership, highest priority first.
    always_comb begin
        pkt_count_next_s = pkt_count_r;
        data_next_s      = data_r;
        oe_next_s        = oe_r;
        if (soft_reset) begin
            pkt_count_next_s = 6'd0;
            oe_next_s        = 1'b0;
        end else if (do_rd_s && rd_word_s[DATA_W]) begin
            // Header length field counts payload bytes; +1 covers the parity byte.
            data_next_s      = rd_word_s[DATA_W-1:0];
            oe_next_s        = 1'b1;
            pkt_count_next_s = 6'(rd_word_s[DATA_W-1:2]) + 6'd1;
        end else if (do_rd_s && (pkt_count_r != 6'd0)) begin
            data_next_s      = rd_word_s[DATA_W-1:0];
            oe_next_s        = 1'b1;
            pkt_count_next_s = pkt_count_r - 6'd1;
        end else if (pkt_count_r == 6'd0) begin
            oe_next_s        = 1'b0;
        end else begin
            pkt_count_next_s = pkt_count_r;
        end
    end

    // Registered read data, bus enable and packet counter.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            pkt_count_r <= 6'd0;
            data_r      <= {DATA_W{1'b0}};
            oe_r        <= 1'b1;
        end else begin
            pkt_count_r <= pkt_count_next_s;
            data_r      <= data_next_s;
            oe_r        <= oe_next_s;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic,
// all compared against a queue-based packet model.
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    wire        full;
    wire        empty;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] q[$];
    int         pc;
    logic [7:0] exp_d;
    bit         exp_z;

    router_fifo #(.DEPTH(16), .DATA_W(8), .PTR_W(5)) dut (
        .clk(clk), .reset_in(reset_in), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] e;
        e = exp_z ? {8{1'bz}} : exp_d;
        check({tag, ".data_out"}, data_out, e);
        check({tag, ".empty"}, {7'd0, empty}, {7'd0, (q.size() == 0)});
        check({tag, ".full"}, {7'd0, full}, {7'd0, (q.size() == 16)});
    endtask

    // One clock: drive on the falling edge, advance the model, sample after the rising edge.
    task automatic cyc(input string tag, input logic we, input logic re, input logic lfd,
                       input logic [7:0] din, input logic sr);
        logic [8:0] w;
        bit do_rd, do_wr;
        @(negedge clk);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        if (sr) begin
            q.delete();
            pc    = 0;
            exp_z = 1'b1;
        end else begin
            do_rd = re && (q.size() > 0);
            do_wr = we && (q.size() < 16);
            w = 9'd0;
            if (do_rd) w = q.pop_front();
            if (do_wr) q.push_back({lfd, din});
            if (do_rd && w[8]) begin
                exp_d = w[7:0];
                exp_z = 1'b0;
                pc    = (int'(w[7:2]) + 1) % 64;
            end else if (do_rd && pc > 0) begin
                exp_d = w[7:0];
                exp_z = 1'b0;
                pc    = pc - 1;
            end else if (pc == 0) begin
                exp_z = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_in = 1'b0;
        write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
        data_in = 8'h00; soft_reset = 1'b0;
        q.delete();
        pc    = 0;
        exp_d = 8'h00;
        exp_z = 1'b0;
        #1;
        check_outputs("reset_async");
        repeat (2) @(negedge clk);
        check_outputs("reset_held");
        reset_in = 1'b1;
        #1;
        check_outputs("reset_release");
    endtask

    initial begin
        reset_in = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        pc = 0; exp_d = 8'h00; exp_z = 1'b0;
        do_reset();
        cyc("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Single packet: header 0E, three payload bytes, parity.
        cyc("sp_wr_hdr", 1'b1, 1'b0, 1'b1, 8'h0E, 1'b0);
        cyc("sp_wr_p0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        cyc("sp_wr_p1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        cyc("sp_wr_p2", 1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        cyc("sp_wr_par", 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0);
        for (int i = 0; i < 5; i++) cyc("sp_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("sp_release", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Full boundary: header announcing 15 more words, 15 payloads, then a dropped FF.
        cyc("fb_wr_hdr", 1'b1, 1'b0, 1'b1, 8'h38, 1'b0);
        for (int i = 0; i < 15; i++) cyc("fb_wr", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
        cyc("fb_wr_drop", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        cyc("fb_wr_drop_rd", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 15; i++) cyc("fb_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("fb_rd_empty", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Concurrent traffic at occupancy 8, crossing the storage index wrap.
        cyc("cc_wr_hdr", 1'b1, 1'b0, 1'b1, 8'h28, 1'b0);
        for (int i = 0; i < 7; i++) cyc("cc_wr", 1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 4; i++) cyc("cc_both", 1'b1, 1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 9; i++) cyc("cc_drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Soft reset mid-packet with a concurrent write.
        cyc("sr_wr_hdr", 1'b1, 1'b0, 1'b1, 8'h0E, 1'b0);
        for (int i = 0; i < 4; i++) cyc("sr_wr", 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 3; i++) cyc("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("sr_pulse", 1'b1, 1'b0, 1'b0, 8'hEE, 1'b1);
        cyc("sr_after", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Back-to-back length-1 packets read continuously.
        cyc("bb_h0", 1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
        cyc("bb_p0", 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
        cyc("bb_q0", 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0);
        cyc("bb_h1", 1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
        cyc("bb_p1", 1'b1, 1'b0, 1'b0, 8'h6B, 1'b0);
        cyc("bb_q1", 1'b1, 1'b0, 1'b0, 8'h9D, 1'b0);
        for (int i = 0; i < 7; i++) cyc("bb_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Random traffic with occasional soft resets and one asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cyc("rnd", 1'($urandom), 1'($urandom), ($urandom % 4) == 0,
                8'($urandom), ($urandom % 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One of three identical output FIFOs in the 1x3 router.
- Sits directly downstream of router_sync, which supplies its write enable and soft reset and consumes its full/empty flags.
- Stores 16 nine-bit words: 8 data bits plus a header-marker bit (lfd).
- Tracks the packet length on the read side so the output port releases the bus (drives high-Z) when a packet ends or on soft reset.

Parameters:
DEPTH, 16, number of storage words (power of two)
DATA_W, 8, data bus width
PTR_W, 5, pointer width: log2(DEPTH)+1, the extra bit is the wrap bit

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_in  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous clear from router_sync timeout (soft_rst_x)
write_enb  input  1  write strobe (write_en[x] from router_sync)
read_enb  input  1  read strobe from the destination client
lfd_state  input  1  marks the current data_in as a packet header; stored as bit 8
data_in  input  DATA_W  byte to store
data_out  output  DATA_W  registered read data; high-Z when idle or after packet end
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds zero words

Behaviour:
- Asynchronous reset (reset_in=0):
  - wr_ptr=0, rd_ptr=0, pkt_count=0.
  - data_out=8'h00 (driven, not Z); full=0; empty=1.
  - Memory contents are don't-care.
- Flags are combinational from the pointers:
  - empty = (wr_ptr==rd_ptr).
  - full = (MSBs differ and the lower PTR_W-1 bits are equal).
- Write: on a rising edge with write_enb=1 and full=0 (pre-edge value):
  - mem[wr_ptr[3:0]] <= {lfd_state, data_in}; wr_ptr increments.
  - A write while full is dropped and wr_ptr is unchanged, even if a read happens in the same cycle.
- Read: a rising edge with read_enb=1 and empty=0 (pre-edge value) is a read.
  - The word at rd_ptr is popped and rd_ptr increments.
  - A read while empty is ignored.
  - Latency: data_out carries the popped byte from the edge of the read (one-cycle registered read).
- Simultaneous read and write with 0 < occupancy < DEPTH: both occur and occupancy is unchanged.
- Pointers wrap modulo 2^PTR_W; the storage index is the low PTR_W-1 bits.
- pkt_count (6 bits) and data_out update per edge in this priority order:
  1. soft_reset=1: pointers=0, pkt_count=0, data_out=8'hZZ. Any concurrent read/write is discarded.
  2. Read of a word with bit8=1 (header): data_out<=word[7:0]; pkt_count<=word[7:2]+1 (payload bytes plus parity).
  3. Read of a word with bit8=0 and pkt_count>0: data_out<=word[7:0]; pkt_count<=pkt_count-1.
  4. pkt_count==0 with no header read (including a stray non-header read, whose word is popped and discarded): data_out<=8'hZZ.
  5. Otherwise data_out and pkt_count hold.
- End of packet: the edge that reads the parity byte leaves pkt_count=0 with the parity on data_out. The next edge without a header read drives Z.
- Back-to-back packets: a header read on the edge right after the parity read drives the new header with no Z cycle.
- Asynchronous reset mid-packet overrides everything immediately. After release, the block behaves exactly as after power-up.
- full and empty respond to soft_reset after the edge: empty=1, full=0.

Test Plan:
- Reset: reset_in=0 for 2 cycles -> data_out=8'h00, empty=1, full=0. Release -> unchanged until stimulus.
- Single packet:
  - Stimulus: write header 8'h0E (len 3, addr 2) with lfd_state=1, then 3 payload bytes 11/22/33 and parity 8'h3A with lfd_state=0. Then read_enb=1 for 5 cycles.
  - Response: data_out=0E,11,22,33,3A on consecutive edges, then ZZ on the 6th edge; empty=1 after the 5th read.
- Full boundary:
  - Stimulus: write 16 words with no reads; then a 17th write of 8'hFF.
  - Response: full=1 after the 16th write. The 17th write is dropped: the 16 reads return the original words, FF never appears, empty=1 at the end.
- Concurrent read/write at occupancy 8: assert both for 4 cycles -> occupancy stays 8, full=0, empty=0; read order matches write order across the pointer wrap.
- Soft reset mid-packet:
  - Stimulus: after the header and 2 payload reads, pulse soft_reset for one cycle with write_enb=1 asserted.
  - Response: data_out=ZZ, empty=1 next cycle, and the concurrent write is not stored.
- Back-to-back packets: queue two packets of payload length 1 and read continuously -> no Z cycle between the first parity and the second header. Z appears only after the second parity.
